// File: rtl/exec_alu_pkg.sv
// exec_alu_pkg: shared widths and internal opcode codes for the integer
// execution unit. The decoder and reservation station use the same codes.
package exec_alu_pkg;

  localparam int DAT_W   = 32;
  localparam int ROB_BIT = 5;
  localparam int OP_W    = 6;

  localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
  localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
  localparam logic [OP_W-1:0] OP_BLT   = 6'd7;
  localparam logic [OP_W-1:0] OP_BGE   = 6'd8;
  localparam logic [OP_W-1:0] OP_BLTU  = 6'd9;
  localparam logic [OP_W-1:0] OP_BGEU  = 6'd10;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd11;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd12;
  localparam logic [OP_W-1:0] OP_SLL   = 6'd13;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd14;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'd15;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd16;
  localparam logic [OP_W-1:0] OP_SRL   = 6'd17;
  localparam logic [OP_W-1:0] OP_SRA   = 6'd18;
  localparam logic [OP_W-1:0] OP_OR    = 6'd19;
  localparam logic [OP_W-1:0] OP_AND   = 6'd20;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd21;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd22;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'd23;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd24;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd25;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd26;
  localparam logic [OP_W-1:0] OP_SLLI  = 6'd27;
  localparam logic [OP_W-1:0] OP_SRLI  = 6'd28;
  localparam logic [OP_W-1:0] OP_SRAI  = 6'd29;

endpackage

// File: rtl/exec_alu_br_cmp.sv
// alu_br_cmp: combinational branch condition evaluator.
// Ports:
//   op_i    - internal opcode
//   vs_i    - rs1 value
//   vt_i    - rs2 value
//   taken_o - condition result for the six branch opcodes, 0 otherwise
module alu_br_cmp
  import exec_alu_pkg::*;
#(
  parameter int DAT_W = exec_alu_pkg::DAT_W,
  parameter int OP_W  = exec_alu_pkg::OP_W
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [DAT_W-1:0] vs_i,
  input  logic [DAT_W-1:0] vt_i,
  output logic             taken_o
);

  logic signed [DAT_W-1:0] vs_s;
  logic signed [DAT_W-1:0] vt_s;
  logic                    eq;
  logic                    lt_s;
  logic                    lt_u;

  assign vs_s = vs_i;
  assign vt_s = vt_i;
  assign eq   = (vs_i == vt_i);
  assign lt_s = (vs_s < vt_s);
  assign lt_u = (vs_i < vt_i);

  always_comb begin
    taken_o = 1'b0;
    case (op_i)
      OP_BEQ:  taken_o = eq;
      OP_BNE:  taken_o = !eq;
      OP_BLT:  taken_o = lt_s;
      OP_BGE:  taken_o = !lt_s;
      OP_BLTU: taken_o = lt_u;
      OP_BGEU: taken_o = !lt_u;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_alu.sv
// exec_alu: single-cycle integer execution unit. Computes ALU, shift, link
// and upper-immediate results and resolves branches/jumps, broadcasting one
// registered result per issue on the CDB.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   en            - global ready; low freezes all state
//   rs_en_i       - issue valid
//   rs_op_i       - internal opcode
//   rs_ic_i       - compressed instruction (link offset 2 instead of 4)
//   rs_qd_i       - destination ROB tag
//   rs_vs_i/vt_i  - rs1 / rs2 values
//   rs_imm_i      - sign-extended immediate
//   rs_pc_i       - instruction PC
//   cdb_en_o      - result valid (one cycle per issue)
//   cdb_q_o       - result ROB tag
//   cdb_v_o       - result value
//   cdb_cbr_o     - computed branch taken
//   cdb_cbt_o     - computed next PC
module exec_alu
  import exec_alu_pkg::*;
#(
  parameter int DAT_W   = exec_alu_pkg::DAT_W,
  parameter int ROB_BIT = exec_alu_pkg::ROB_BIT,
  parameter int OP_W    = exec_alu_pkg::OP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               rs_en_i,
  input  logic [OP_W-1:0]    rs_op_i,
  input  logic               rs_ic_i,
  input  logic [ROB_BIT-1:0] rs_qd_i,
  input  logic [DAT_W-1:0]   rs_vs_i,
  input  logic [DAT_W-1:0]   rs_vt_i,
  input  logic [DAT_W-1:0]   rs_imm_i,
  input  logic [DAT_W-1:0]   rs_pc_i,
  output logic               cdb_en_o,
  output logic [ROB_BIT-1:0] cdb_q_o,
  output logic [DAT_W-1:0]   cdb_v_o,
  output logic               cdb_cbr_o,
  output logic [DAT_W-1:0]   cdb_cbt_o
);

  function automatic logic [DAT_W-1:0] sra_f(input logic [DAT_W-1:0] a,
                                             input logic [4:0]       sh);
    logic signed [DAT_W-1:0] a_s;
    a_s = a;
    return a_s >>> sh;
  endfunction

  function automatic logic [DAT_W-1:0] bool_f(input logic b);
    return {{(DAT_W-1){1'b0}}, b};
  endfunction

  logic signed [DAT_W-1:0] vs_s;
  logic signed [DAT_W-1:0] vt_s;
  logic signed [DAT_W-1:0] imm_s;
  logic [DAT_W-1:0]        len;
  logic [DAT_W-1:0]        link;
  logic [DAT_W-1:0]        pc_imm;
  logic [DAT_W-1:0]        jalr_sum;
  logic [4:0]              sh_r;
  logic [4:0]              sh_i;
  logic                    br_taken;

  logic [DAT_W-1:0]        res_v_d;
  logic                    res_cbr_d;
  logic [DAT_W-1:0]        res_cbt_d;

  logic                    cdb_en_q;
  logic [ROB_BIT-1:0]      cdb_q_q;
  logic [DAT_W-1:0]        cdb_v_q;
  logic                    cdb_cbr_q;
  logic [DAT_W-1:0]        cdb_cbt_q;

  assign vs_s     = rs_vs_i;
  assign vt_s     = rs_vt_i;
  assign imm_s    = rs_imm_i;
  assign len      = rs_ic_i ? DAT_W'(2) : DAT_W'(4);
  assign link     = rs_pc_i + len;
  assign pc_imm   = rs_pc_i + rs_imm_i;
  assign jalr_sum = rs_vs_i + rs_imm_i;
  assign sh_r     = rs_vt_i[4:0];
  assign sh_i     = rs_imm_i[4:0];

  alu_br_cmp #(
    .DAT_W (DAT_W),
    .OP_W  (OP_W)
  ) u_br_cmp (
    .op_i    (rs_op_i),
    .vs_i    (rs_vs_i),
    .vt_i    (rs_vt_i),
    .taken_o (br_taken)
  );

  always_comb begin
    res_v_d   = '0;
    res_cbr_d = 1'b0;
    res_cbt_d = '0;
    case (rs_op_i)
      OP_LUI:   res_v_d = rs_imm_i;
      OP_AUIPC: res_v_d = pc_imm;
      OP_JAL: begin
        res_v_d   = link;
        res_cbr_d = 1'b1;
        res_cbt_d = pc_imm;
      end
      OP_JALR: begin
        res_v_d   = link;
        res_cbr_d = 1'b1;
        res_cbt_d = {jalr_sum[DAT_W-1:1], 1'b0};
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        res_cbr_d = br_taken;
        res_cbt_d = br_taken ? pc_imm : link;
      end
      OP_ADD:   res_v_d = rs_vs_i + rs_vt_i;
      OP_SUB:   res_v_d = rs_vs_i - rs_vt_i;
      OP_SLL:   res_v_d = rs_vs_i << sh_r;
      OP_SLT:   res_v_d = bool_f(vs_s < vt_s);
      OP_SLTU:  res_v_d = bool_f(rs_vs_i < rs_vt_i);
      OP_XOR:   res_v_d = rs_vs_i ^ rs_vt_i;
      OP_SRL:   res_v_d = rs_vs_i >> sh_r;
      OP_SRA:   res_v_d = sra_f(rs_vs_i, sh_r);
      OP_OR:    res_v_d = rs_vs_i | rs_vt_i;
      OP_AND:   res_v_d = rs_vs_i & rs_vt_i;
      OP_ADDI:  res_v_d = rs_vs_i + rs_imm_i;
      OP_SLTI:  res_v_d = bool_f(vs_s < imm_s);
      OP_SLTIU: res_v_d = bool_f(rs_vs_i < rs_imm_i);
      OP_XORI:  res_v_d = rs_vs_i ^ rs_imm_i;
      OP_ORI:   res_v_d = rs_vs_i | rs_imm_i;
      OP_ANDI:  res_v_d = rs_vs_i & rs_imm_i;
      OP_SLLI:  res_v_d = rs_vs_i << sh_i;
      OP_SRLI:  res_v_d = rs_vs_i >> sh_i;
      OP_SRAI:  res_v_d = sra_f(rs_vs_i, sh_i);
      default: begin
        res_v_d   = '0;
        res_cbr_d = 1'b0;
        res_cbt_d = '0;
      end
    endcase
  end

  // ---- output register: result mux -> CDB ----
  // Payload only loads on a valid issue so an idle cycle keeps the last
  // broadcast value visible while cdb_en drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_en_q  <= 1'b0;
      cdb_q_q   <= '0;
      cdb_v_q   <= '0;
      cdb_cbr_q <= 1'b0;
      cdb_cbt_q <= '0;
    end else if (en) begin
      cdb_en_q <= rs_en_i;
      if (rs_en_i) begin
        cdb_q_q   <= rs_qd_i;
        cdb_v_q   <= res_v_d;
        cdb_cbr_q <= res_cbr_d;
        cdb_cbt_q <= res_cbt_d;
      end
    end
  end

  assign cdb_en_o  = cdb_en_q;
  assign cdb_q_o   = cdb_q_q;
  assign cdb_v_o   = cdb_v_q;
  assign cdb_cbr_o = cdb_cbr_q;
  assign cdb_cbt_o = cdb_cbt_q;

endmodule

// File: tb/tb_exec_alu.sv
// tb_exec_alu: directed vector table, hand-written control sequences and a
// randomized run against a behavioural model for exec_alu.
module tb_exec_alu;
  import exec_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rs_en_i;
  logic [5:0]  rs_op_i;
  logic        rs_ic_i;
  logic [4:0]  rs_qd_i;
  logic [31:0] rs_vs_i, rs_vt_i, rs_imm_i, rs_pc_i;
  logic        cdb_en_o;
  logic [4:0]  cdb_q_o;
  logic [31:0] cdb_v_o;
  logic        cdb_cbr_o;
  logic [31:0] cdb_cbt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exec_alu dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rs_en_i   (rs_en_i),
    .rs_op_i   (rs_op_i),
    .rs_ic_i   (rs_ic_i),
    .rs_qd_i   (rs_qd_i),
    .rs_vs_i   (rs_vs_i),
    .rs_vt_i   (rs_vt_i),
    .rs_imm_i  (rs_imm_i),
    .rs_pc_i   (rs_pc_i),
    .cdb_en_o  (cdb_en_o),
    .cdb_q_o   (cdb_q_o),
    .cdb_v_o   (cdb_v_o),
    .cdb_cbr_o (cdb_cbr_o),
    .cdb_cbt_o (cdb_cbt_o)
  );

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        ic;
    logic [4:0]  qd;
    logic [31:0] vs, vt, imm, pc;
    logic [31:0] v;
    logic        cbr;
    logic [31:0] cbt;
  } vec_t;

  vec_t tbl[18];

  // Behavioural reference: straight from the opcode descriptions.
  function automatic logic [31:0] arith(input int k, input logic [31:0] a,
                                        input logic [31:0] b);
    int          sa;
    int          sb;
    int unsigned sh;
    sa = a;
    sb = b;
    sh = b % 32;
    case (k)
      0: return a + b;
      1: return a - b;
      2: return a * (32'd1 << sh);
      3: return (sa < sb) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a / (33'd1 << sh);
      7: return sa >>> sh;
      8: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model(input logic [5:0] op, input logic ic,
                       input logic [31:0] vs, vt, imm, pc,
                       output logic [31:0] v, output logic cbr,
                       output logic [31:0] cbt);
    logic [31:0] len;
    int          sa, sb;
    int          imap[9] = '{0, 3, 4, 5, 8, 9, 2, 6, 7};
    len = ic ? 32'd2 : 32'd4;
    sa = vs;
    sb = vt;
    v = 0; cbr = 0; cbt = 0;
    if (op == 1) v = imm;
    else if (op == 2) v = pc + imm;
    else if (op == 3) begin v = pc + len; cbr = 1; cbt = pc + imm; end
    else if (op == 4) begin v = pc + len; cbr = 1; cbt = (vs + imm) & 32'hFFFF_FFFE; end
    else if (op >= 5 && op <= 10) begin
      case (op)
        5:  cbr = (vs == vt);
        6:  cbr = (vs != vt);
        7:  cbr = (sa < sb);
        8:  cbr = (sa >= sb);
        9:  cbr = (vs < vt);
        default: cbr = (vs >= vt);
      endcase
      cbt = cbr ? pc + imm : pc + len;
    end
    else if (op >= 11 && op <= 20) v = arith(int'(op) - 11, vs, vt);
    else if (op >= 21 && op <= 29) v = arith(imap[int'(op) - 21], vs, imm);
  endtask

  task automatic drive(input logic r, input logic e, input logic rse,
                       input logic [5:0] op, input logic ic, input logic [4:0] qd,
                       input logic [31:0] vs, vt, imm, pc);
    @(negedge clk);
    rst = r; en = e; rs_en_i = rse; rs_op_i = op; rs_ic_i = ic;
    rs_qd_i = qd; rs_vs_i = vs; rs_vt_i = vt; rs_imm_i = imm; rs_pc_i = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic xen, input logic [4:0] xq,
                       input logic [31:0] xv, input logic xcbr, input logic [31:0] xcbt);
    n_vec++;
    if (cdb_en_o !== xen || cdb_q_o !== xq || cdb_v_o !== xv ||
        cdb_cbr_o !== xcbr || cdb_cbt_o !== xcbt) begin
      n_err++;
      $display("FAIL %s: got en=%0b q=%0d v=%h cbr=%0b cbt=%h, want en=%0b q=%0d v=%h cbr=%0b cbt=%h",
               nm, cdb_en_o, cdb_q_o, cdb_v_o, cdb_cbr_o, cdb_cbt_o,
               xen, xq, xv, xcbr, xcbt);
    end
  endtask

  logic        e_en;
  logic [4:0]  e_q;
  logic [31:0] e_v, e_cbt;
  logic        e_cbr;

  initial begin
    tbl[0]  = '{"add_ovf",   OP_ADD,   0, 3, 32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 0, 0};
    tbl[1]  = '{"srai",      OP_SRAI,  0, 1, 32'h80000000, 0, 32'h23, 0, 32'hF0000000, 0, 0};
    tbl[2]  = '{"srli",      OP_SRLI,  0, 2, 32'h80000000, 0, 32'h23, 0, 32'h10000000, 0, 0};
    tbl[3]  = '{"slt",       OP_SLT,   0, 4, 32'hFFFFFFFF, 32'h1, 0, 0, 32'h1, 0, 0};
    tbl[4]  = '{"sltu",      OP_SLTU,  0, 5, 32'hFFFFFFFF, 32'h1, 0, 0, 32'h0, 0, 0};
    tbl[5]  = '{"bne_tk",    OP_BNE,   0, 6, 32'h1, 32'h2, 32'h20, 32'h100, 0, 1, 32'h120};
    tbl[6]  = '{"bne_nt_c",  OP_BNE,   1, 7, 32'h5, 32'h5, 32'h20, 32'h100, 0, 0, 32'h102};
    tbl[7]  = '{"jalr",      OP_JALR,  0, 8, 32'h1001, 0, 32'h2, 32'h200, 32'h204, 1, 32'h1002};
    tbl[8]  = '{"addi_wrap", OP_ADDI,  0, 9, 32'hFFFFFFFF, 0, 32'h1, 0, 32'h0, 0, 0};
    tbl[9]  = '{"jalr_wrap", OP_JALR,  1, 10, 32'hFFFFFFFF, 0, 32'h3, 32'h40, 32'h42, 1, 32'h2};
    tbl[10] = '{"sll_31",    OP_SLL,   0, 11, 32'h1, 32'hFFFFFFFF, 0, 0, 32'h80000000, 0, 0};
    tbl[11] = '{"sra_31",    OP_SRA,   0, 12, 32'h80000000, 32'h0000003F, 0, 0, 32'hFFFFFFFF, 0, 0};
    tbl[12] = '{"jal_c",     OP_JAL,   1, 13, 0, 0, 32'hFFFFFFF8, 32'h10, 32'h12, 1, 32'h8};
    tbl[13] = '{"lui",       OP_LUI,   0, 14, 32'h5, 32'h6, 32'hABCDE000, 32'h10, 32'hABCDE000, 0, 0};
    tbl[14] = '{"auipc",     OP_AUIPC, 0, 15, 0, 0, 32'h1000, 32'h300, 32'h1300, 0, 0};
    tbl[15] = '{"bge_s",     OP_BGE,   0, 16, 32'h1, 32'hFFFFFFFF, 32'h40, 32'h80, 0, 1, 32'hC0};
    tbl[16] = '{"bgeu_nt",   OP_BGEU,  0, 17, 32'h1, 32'hFFFFFFFF, 32'h40, 32'h80, 0, 0, 32'h84};
    tbl[17] = '{"undef_63",  6'd63,    0, 18, 32'h1234, 32'h5678, 32'h9, 32'h80, 0, 0, 0};

    rst = 1; en = 1; rs_en_i = 0; rs_op_i = 0; rs_ic_i = 0; rs_qd_i = 0;
    rs_vs_i = 0; rs_vt_i = 0; rs_imm_i = 0; rs_pc_i = 0;
    drive(1, 1, 1, OP_ADD, 0, 5'd7, 32'h1, 32'h2, 0, 0);
    check("reset", 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(0, 1, 1, tbl[i].op, tbl[i].ic, tbl[i].qd, tbl[i].vs, tbl[i].vt,
            tbl[i].imm, tbl[i].pc);
      check(tbl[i].name, 1, tbl[i].qd, tbl[i].v, tbl[i].cbr, tbl[i].cbt);
    end

    // Idle after issue: valid drops, payload keeps last result (bgeu/undef -> 0s).
    drive(0, 1, 1, OP_JAL, 0, 5'd21, 0, 0, 32'h10, 32'h400);
    check("jal", 1, 21, 32'h404, 1, 32'h410);
    drive(0, 1, 0, OP_ADD, 0, 5'd22, 32'h1, 32'h1, 0, 0);
    check("idle_hold", 0, 21, 32'h404, 1, 32'h410);
    // en low: nothing moves, including a new issue.
    drive(0, 1, 1, OP_SUB, 0, 5'd23, 32'h10, 32'h3, 0, 0);
    check("sub", 1, 23, 32'hD, 0, 0);
    drive(0, 0, 1, OP_OR, 0, 5'd24, 32'hF0, 32'h0F, 0, 0);
    check("en_low_hold", 1, 23, 32'hD, 0, 0);
    drive(0, 0, 0, OP_OR, 0, 5'd24, 32'hF0, 32'h0F, 0, 0);
    check("en_low_hold2", 1, 23, 32'hD, 0, 0);
    // Reset beats en and issue.
    drive(1, 0, 1, OP_JAL, 0, 5'd25, 0, 0, 32'h10, 32'h400);
    check("rst_prio", 0, 0, 0, 0, 0);

    // Randomized back-to-back traffic against the model.
    e_en = 0; e_q = 0; e_v = 0; e_cbr = 0; e_cbt = 0;
    for (int n = 0; n < 400; n++) begin
      logic        r_e, r_rse, r_ic, m_cbr;
      logic [5:0]  r_op;
      logic [4:0]  r_qd;
      logic [31:0] r_vs, r_vt, r_imm, r_pc, m_v, m_cbt;
      r_e   = ($urandom_range(0, 9) != 0);
      r_rse = ($urandom_range(0, 3) != 0);
      r_ic  = $urandom_range(0, 1);
      r_op  = 6'($urandom_range(0, 34));
      r_qd  = 5'($urandom);
      r_vs  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      r_vt  = ($urandom_range(0, 7) == 0) ? r_vs : $urandom;
      r_imm = $urandom;
      r_pc  = $urandom & 32'hFFFF_FFFE;
      drive(0, r_e, r_rse, r_op, r_ic, r_qd, r_vs, r_vt, r_imm, r_pc);
      if (r_e) begin
        e_en = r_rse;
        if (r_rse) begin
          model(r_op, r_ic, r_vs, r_vt, r_imm, r_pc, m_v, m_cbr, m_cbt);
          e_q = r_qd; e_v = m_v; e_cbr = m_cbr; e_cbt = m_cbt;
        end
      end
      check($sformatf("rand%0d_op%0d", n, r_op), e_en, e_q, e_v, e_cbr, e_cbt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
